// File: rtl/cam_alloc_pkg.sv
// Shared types for the cam write-side allocator.
// State encoding and request op codes.
package cam_alloc_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SEARCH,
        WRITE,
        RESP
    } state_t;

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_DELETE = 1'b1;

endpackage

// File: rtl/cam_alloc_pri_enc.sv
// Lowest-set-bit priority encoder.
// Returns the index of the lowest set request bit and a found flag.
module cam_alloc_pri_enc #(
    parameter int DEPTH = 32,
    localparam int ADDR = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic [ADDR-1:0]  idx,
    output logic             found
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = ADDR'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_alloc.sv
// Write-side owner of one cam: search-before-write insert/delete,
// free-entry allocation and round-robin eviction when full.
module cam_alloc
    import cam_alloc_pkg::*;
#(
    parameter int              DATA      = 32,
    parameter int              DEPTH     = 32,
    parameter logic [DATA-1:0] TOMBSTONE = {DATA{1'b1}},
    localparam int             ADDR      = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_op,
    input  logic [DATA-1:0] req_data,
    output logic            resp_valid,
    output logic [ADDR-1:0] resp_addr,
    output logic            resp_hit,
    output logic            resp_evict,
    output logic            resp_err,
    output logic            cam_we_,
    output logic [DATA-1:0] cam_wm,
    output logic [DATA-1:0] cam_wd,
    output logic [ADDR-1:0] cam_waddr,
    output logic            cam_re_,
    output logic [DATA-1:0] cam_rm,
    output logic [DATA-1:0] cam_rd,
    input  logic            cam_match,
    input  logic            cam_multi,
    input  logic [ADDR-1:0] cam_raddr,
    output logic [ADDR:0]   count,
    output logic            full
);

    state_t            state, state_nx;
    logic [DEPTH-1:0]  valid;
    logic [ADDR-1:0]   victim;
    logic [ADDR-1:0]   init_ptr;
    logic              op_q;
    logic [DATA-1:0]   key_q;
    logic [ADDR-1:0]   addr_q;
    logic              hit_q;
    logic              evict_q;
    logic              err_q;
    logic [ADDR-1:0]   free_idx;
    logic              free_found;
    logic              hit;
    logic              bad;
    logic              need_write;

    cam_alloc_pri_enc #(.DEPTH(DEPTH)) u_pri_enc (
        .req   (~valid),
        .idx   (free_idx),
        .found (free_found)
    );

    assign full   = (count == (ADDR+1)'(DEPTH));
    assign hit    = cam_match & valid[cam_raddr];
    assign bad    = (key_q == TOMBSTONE) | (hit & cam_multi);
    assign cam_wm = '0;
    assign cam_rm = '0;

    // Insert misses and delete hits are the only searches that write.
    always_comb begin
        need_write = 1'b0;
        if (!bad) begin
            if (op_q == OP_INSERT)
                need_write = !hit;
            else
                need_write = hit;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= INIT;
        else
            state <= state_nx;
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        unique case (state)
            INIT:    if (init_ptr == ADDR'(DEPTH - 1)) state_nx = IDLE;
            IDLE:    if (req_valid) state_nx = SEARCH;
            SEARCH:  state_nx = need_write ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = INIT;
        endcase
    end

    // Request latch, search decision and allocation bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= '0;
            count    <= '0;
            victim   <= '0;
            init_ptr <= '0;
            op_q     <= OP_INSERT;
            key_q    <= '0;
            addr_q   <= '0;
            hit_q    <= 1'b0;
            evict_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                INIT: init_ptr <= init_ptr + ADDR'(1);
                IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        key_q <= req_data;
                    end
                end
                SEARCH: begin
                    addr_q  <= '0;
                    hit_q   <= 1'b0;
                    evict_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (bad) begin
                        err_q <= 1'b1;
                    end else if (hit) begin
                        hit_q  <= 1'b1;
                        addr_q <= cam_raddr;
                    end else if (op_q == OP_INSERT) begin
                        if (!full && free_found) begin
                            addr_q <= free_idx;
                        end else begin
                            addr_q  <= victim;
                            evict_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (op_q == OP_INSERT) begin
                        valid[addr_q] <= 1'b1;
                        if (evict_q) begin
                            if (victim == ADDR'(DEPTH - 1))
                                victim <= '0;
                            else
                                victim <= victim + ADDR'(1);
                        end else begin
                            count <= count + (ADDR+1)'(1);
                        end
                    end else begin
                        valid[addr_q] <= 1'b0;
                        count         <= count - (ADDR+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Cam strobes and response outputs; all idle while reset is high.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_addr  = '0;
        resp_hit   = 1'b0;
        resp_evict = 1'b0;
        resp_err   = 1'b0;
        cam_we_    = 1'b1;
        cam_wd     = '0;
        cam_waddr  = '0;
        cam_re_    = 1'b1;
        cam_rd     = '0;
        if (!reset) begin
            unique case (state)
                INIT: begin
                    cam_we_   = 1'b0;
                    cam_waddr = init_ptr;
                    cam_wd    = TOMBSTONE;
                end
                IDLE: req_ready = 1'b1;
                SEARCH: begin
                    cam_re_ = 1'b0;
                    cam_rd  = key_q;
                end
                WRITE: begin
                    cam_we_   = 1'b0;
                    cam_waddr = addr_q;
                    cam_wd    = (op_q == OP_DELETE) ? TOMBSTONE : key_q;
                end
                RESP: begin
                    resp_valid = 1'b1;
                    resp_addr  = addr_q;
                    resp_hit   = hit_q;
                    resp_evict = evict_q;
                    resp_err   = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule
